delaybuf_sink: RTL and testbench
================================

DELAYBUF_SINK -- requirements
Module: delaybuf_sink

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 The module SHALL have parameter DEPTH, default FFT_LEN (64), delay in enabled samples of the upstream DelayBuf.
REQ-003 The module SHALL have parameter NCHECK, default 128, number of samples compared per run.
REQ-004 The module SHALL have parameter SEED, default 0, first expected sample value.
REQ-005 The module SHALL have parameter ERRW, default 16, error-counter width.
REQ-006 Ports SHALL be:
  clk  input  1  single clock, all logic on rising edge
  rst  input  1  asynchronous, active-low reset
  start  input  1  single-cycle pulse, begins a run
  en  input  1  sample strobe, same strobe that drives the DelayBuf
  dout  input  WIDTH  DelayBuf output sample
  busy  output  1  high from start accept until done
  done  output  1  high, sticky, after NCHECK compares
  pass  output  1  high with done when err_cnt is 0
  err_cnt  output  ERRW  mismatch count, saturating
  first_err_idx  output  $clog2(NCHECK)+1  compare index of first mismatch
  first_err_val  output  WIDTH  dout value at first mismatch

Function
REQ-007 The FSM SHALL have states IDLE, PRIME, CHECK and DONE.
REQ-008 In IDLE, start=1 SHALL move the FSM to PRIME, clear err_cnt, done, pass and the first-error registers, and load expected=SEED.
REQ-009 In PRIME, the module SHALL count enabled cycles (en=1) and ignore dout.
REQ-010 After exactly DEPTH enabled cycles in PRIME, the FSM SHALL move to CHECK, so the first compare uses the enabled cycle numbered DEPTH after start.
REQ-011 In CHECK, on each en=1 cycle, the module SHALL compare dout with expected, then advance expected by 1 modulo 2^WIDTH (SEED=2^WIDTH-1 wraps to 0).
REQ-012 Cycles with en=0 SHALL NOT advance any counter, compare or change state in PRIME or CHECK.
REQ-013 On a mismatch, err_cnt SHALL increment by 1 and hold at 2^ERRW-1 (no wrap).
REQ-014 first_err_idx/first_err_val SHALL capture on the first mismatch of a run only (compare index 0-based).
REQ-015 After NCHECK compares, the FSM SHALL enter DONE on the next edge, with done=1, pass=(err_cnt==0) including the final compare, and busy=0.
REQ-016 In DONE, start=1 SHALL restart exactly as from IDLE; start in PRIME or CHECK SHALL be ignored.
REQ-017 If start and en are both 1 in the accepting cycle, that en SHALL NOT count toward PRIME.
REQ-018 All outputs SHALL be registered; compare-to-err_cnt latency SHALL be 1 clock.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE and busy, done, pass, err_cnt, first_err_idx, first_err_val and all counters to 0.
REQ-020 Reset asserted mid-run SHALL abort the run; after release the module SHALL wait in IDLE for start.

Configuration
REQ-021 With DELAYBUF_SINK_FIRSTERR_EN defined, the first-error capture registers SHALL be built as specified.
REQ-022 Without DELAYBUF_SINK_FIRSTERR_EN, first_err_idx and first_err_val SHALL be tied to 0 and no capture registers SHALL exist; all other behaviour is unchanged.

Structure
REQ-023 The sink_state_t enum (IDLE, PRIME, CHECK, DONE) SHALL live in alpaca_ospfb_constants_pkg alongside WIDTH and FFT_LEN.
REQ-024 The expected-value generator SHALL be a sub-module, seq_gen (load, advance, value), so a matching RTL source can reuse it.

Verification
REQ-025 Continuous en=1, DelayBuf DEPTH=64 fed a counter from SEED=0, start pulse -> done after 64+128 enabled cycles, pass=1, err_cnt=0.
REQ-026 Same stimulus with dout bit 0 forced inverted at compare index 5 only -> err_cnt=1, first_err_idx=5, first_err_val=expected^1, pass=0.
REQ-027 en toggling 1,0,1,0 -> done timing doubles (about 384 cycles), pass=1, and no counter moves on en=0 cycles.
REQ-028 SEED=16'hFFFE, WIDTH=16 -> compares 16'hFFFE, 16'hFFFF, 16'h0000 pass with no errors.
REQ-029 ERRW=4 with dout stuck at 0 -> err_cnt saturates at 15; rst=0 mid-CHECK -> all outputs 0 immediately and state IDLE.
REQ-030 Build without DELAYBUF_SINK_FIRSTERR_EN and repeat REQ-026 -> err_cnt=1, first_err_idx=0, first_err_val=0.

Source files
------------

// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared constants and sink FSM state encoding for the OSPFB delay-buffer checker.
// Consumers: delaybuf_sink (optional DELAYBUF_SINK_FIRSTERR_EN) and seq_gen.
package alpaca_ospfb_constants_pkg;

  localparam int WIDTH   = 16;
  localparam int FFT_LEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sink_state_t;

endpackage

// File: rtl/delaybuf_sink_seq_gen.sv
// seq_gen: expected-value generator, loads SEED and steps by one (mod 2^WIDTH) on advance.
// Kept standalone so a matching pattern source can reuse the same sequence.
module seq_gen
  import alpaca_ospfb_constants_pkg::*;
#(
  parameter int               WIDTH = alpaca_ospfb_constants_pkg::WIDTH,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= SEED;
    end else if (advance) begin
      value_q <= value_q + WIDTH'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/delaybuf_sink.sv
// delaybuf_sink: checks a DelayBuf output against a counting sequence after a DEPTH-sample prime.
// Define DELAYBUF_SINK_FIRSTERR_EN to build the first-mismatch capture registers.
module delaybuf_sink #(
  parameter int               WIDTH  = alpaca_ospfb_constants_pkg::WIDTH,
  parameter int               DEPTH  = alpaca_ospfb_constants_pkg::FFT_LEN,
  parameter int               NCHECK = 128,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int               ERRW   = 16,
  localparam int              IDXW   = $clog2(NCHECK) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_cnt,
  output logic [IDXW-1:0]  first_err_idx,
  output logic [WIDTH-1:0] first_err_val
);

  import alpaca_ospfb_constants_pkg::*;

  localparam int PCW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;
  localparam int CCW = $clog2(NCHECK + 1);
  localparam logic [ERRW-1:0] ERR_MAX = '1;
  localparam sink_state_t START_STATE = (DEPTH == 0) ? CHECK : PRIME;

  sink_state_t      state_q;
  logic [PCW-1:0]   prime_cnt_q;
  logic [CCW-1:0]   chk_cnt_q;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  logic             busy_q, done_q, pass_q;
  logic [WIDTH-1:0] exp_val;
  logic             accept, cmp_en, mismatch, last_cmp;

  // Start is only honoured between runs; mid-run pulses are dropped.
  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign cmp_en   = (state_q == CHECK) && en;
  assign mismatch = cmp_en && (dout != exp_val);
  assign last_cmp = cmp_en && (chk_cnt_q == CCW'(NCHECK - 1));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mismatch && err_cnt_q != ERR_MAX) begin
      err_cnt_d = err_cnt_q + ERRW'(1);
    end
  end

  seq_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_seq_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance (cmp_en),
    .value   (exp_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prime_cnt_q <= '0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= START_STATE;
            prime_cnt_q <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        PRIME: begin
          if (en) begin
            if (prime_cnt_q == PCW'(DEPTH - 1)) begin
              state_q     <= CHECK;
              prime_cnt_q <= '0;
            end else begin
              prime_cnt_q <= prime_cnt_q + PCW'(1);
            end
          end
        end
        CHECK: begin
          if (en) begin
            err_cnt_q <= err_cnt_d;
            chk_cnt_q <= chk_cnt_q + CCW'(1);
            // Verdict includes the final compare, so it uses the next-state count.
            if (last_cmp) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;

`ifdef DELAYBUF_SINK_FIRSTERR_EN
  logic [IDXW-1:0]  first_idx_q;
  logic [WIDTH-1:0] first_val_q;

  // A zero error count means this mismatch is the first one of the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_idx_q <= '0;
      first_val_q <= '0;
    end else if (accept) begin
      first_idx_q <= '0;
      first_val_q <= '0;
    end else if (mismatch && err_cnt_q == '0) begin
      first_idx_q <= IDXW'(chk_cnt_q);
      first_val_q <= dout;
    end
  end

  assign first_err_idx = first_idx_q;
  assign first_err_val = first_val_q;
`else
  assign first_err_idx = '0;
  assign first_err_val = '0;
`endif

endmodule

// File: tb/tb_delaybuf_sink.sv
// Bench for delaybuf_sink: two instances (default and short/wrapping/4-bit-error config)
// checked every cycle against a sample-count model, plus literal end-of-run checks.
module tb_delaybuf_sink;

`ifdef DELAYBUF_SINK_FIRSTERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  localparam int DEP[2]  = '{64, 4};
  localparam int NCK[2]  = '{128, 20};
  localparam int SD[2]   = '{0, 65534};
  localparam int EMAX[2] = '{65535, 15};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s[2];
  logic        en_s[2];
  logic [15:0] dout_s[2];

  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0;
  logic [3:0]  err1;
  logic [7:0]  fidx0;
  logic [5:0]  fidx1;
  logic [15:0] fval0, fval1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  delaybuf_sink u_dut0 (
    .clk(clk), .rst(rst_n), .start(start_s[0]), .en(en_s[0]), .dout(dout_s[0]),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_idx(fidx0), .first_err_val(fval0)
  );

  delaybuf_sink #(
    .WIDTH(16), .DEPTH(4), .NCHECK(20), .SEED(16'hFFFE), .ERRW(4)
  ) u_dut1 (
    .clk(clk), .rst(rst_n), .start(start_s[1]), .en(en_s[1]), .dout(dout_s[1]),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_idx(fidx1), .first_err_val(fval1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is "enabled samples seen since start"; sample k >= DEPTH is compare k-DEPTH.
  bit m_act[2], m_done[2], m_pass[2];
  int m_k[2], m_errs[2], m_fidx[2], m_fval[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_act[m] <= 0; m_done[m] <= 0; m_pass[m] <= 0;
        m_k[m] <= 0; m_errs[m] <= 0; m_fidx[m] <= 0; m_fval[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        automatic bit a = m_act[m], d = m_done[m], p = m_pass[m];
        automatic int kk = m_k[m], ee = m_errs[m], fi = m_fidx[m], fv = m_fval[m];
        automatic int idx, expv;
        if (start_s[m] && !a) begin
          a = 1; d = 0; p = 0; kk = 0; ee = 0; fi = 0; fv = 0;
        end else if (a && en_s[m]) begin
          if (kk >= DEP[m]) begin
            idx  = kk - DEP[m];
            expv = (SD[m] + idx) % 65536;
            if (int'(dout_s[m]) != expv) begin
              if (ee == 0) begin
                fi = idx;
                fv = int'(dout_s[m]);
              end
              ee++;
            end
          end
          kk++;
          if (kk == DEP[m] + NCK[m]) begin
            a = 0; d = 1; p = (ee == 0);
          end
        end
        m_act[m] <= a; m_done[m] <= d; m_pass[m] <= p;
        m_k[m] <= kk; m_errs[m] <= ee; m_fidx[m] <= fi; m_fval[m] <= fv;
      end
    end
  end

  task automatic cmp_inst(input int m, input int b, input int d, input int p,
                          input int e, input int fi, input int fv);
    chk($sformatf("i%0d.busy", m), b, int'(m_act[m]));
    chk($sformatf("i%0d.done", m), d, int'(m_done[m]));
    chk($sformatf("i%0d.pass", m), p, int'(m_pass[m]));
    chk($sformatf("i%0d.err_cnt", m), e, (m_errs[m] > EMAX[m]) ? EMAX[m] : m_errs[m]);
    chk($sformatf("i%0d.first_err_idx", m), fi, FE ? m_fidx[m] : 0);
    chk($sformatf("i%0d.first_err_val", m), fv, FE ? m_fval[m] : 0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst(0, int'(busy0), int'(done0), int'(pass0), int'(err0), int'(fidx0), int'(fval0));
      cmp_inst(1, int'(busy1), int'(done1), int'(pass1), int'(err1), int'(fidx1), int'(fval1));
    end
  end

  // One run: start (with en=1), then feed the delayed counter until done or a bound expires.
  task automatic run(input int m, input bit toggle, input int fault_idx, input bit stuck,
                     input int abort_at, input int glitch_at, output int cyc);
    int k;
    @(posedge clk); #1;
    start_s[m] = 1'b1; en_s[m] = 1'b1; dout_s[m] = 16'($urandom);
    @(posedge clk); #1;
    start_s[m] = 1'b0;
    k = 0;
    cyc = 0;
    while (cyc < 2000) begin
      en_s[m]    = toggle ? ((cyc % 2) == 0) : 1'b1;
      start_s[m] = (cyc == glitch_at);
      if (stuck) dout_s[m] = '0;
      else if (en_s[m] && k >= DEP[m]) dout_s[m] = 16'((SD[m] + k - DEP[m]) % 65536);
      else dout_s[m] = 16'($urandom);
      if (en_s[m] && (k - DEP[m]) == fault_idx) dout_s[m] = dout_s[m] ^ 16'h0001;
      @(posedge clk);
      if (en_s[m]) k++;
      cyc++;
      #1;
      start_s[m] = 1'b0;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort.busy1", int'(busy1), 0);
        chk("abort.done1", int'(done1), 0);
        chk("abort.pass1", int'(pass1), 0);
        chk("abort.err1", int'(err1), 0);
        chk("abort.fidx1", int'(fidx1), 0);
        chk("abort.fval1", int'(fval1), 0);
        chk("abort.done0", int'(done0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if ((m == 0 && done0) || (m == 1 && done1)) break;
    end
    en_s[m] = 1'b0;
    if (abort_at < 0) chk($sformatf("i%0d.run_timeout", m), (cyc < 2000) ? 1 : 0, 1);
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      start_s[m] = 1'b0; en_s[m] = 1'b0; dout_s[m] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy0", int'(busy0), 0);
    chk("reset.done0", int'(done0), 0);
    chk("reset.err0", int'(err0), 0);
    chk("reset.busy1", int'(busy1), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Clean run, continuous enable, a stray start mid-CHECK.
    run(0, 0, -1, 0, -1, 100, cyc);
    $display("run0 clean: cycles=%0d err=%0d pass=%0d", cyc, err0, pass0);
    chk("clean.cycles", cyc, 192);
    chk("clean.pass", int'(pass0), 1);
    chk("clean.err", int'(err0), 0);

    // Restart from DONE with bit 0 flipped at compare index 5.
    run(0, 0, 5, 0, -1, -1, cyc);
    $display("run0 fault5: cycles=%0d err=%0d idx=%0d val=%0d", cyc, err0, fidx0, fval0);
    chk("fault.err", int'(err0), 1);
    chk("fault.pass", int'(pass0), 0);
    chk("fault.idx", int'(fidx0), FE ? 5 : 0);
    chk("fault.val", int'(fval0), FE ? 4 : 0);

    // Enable toggling doubles the run length.
    run(0, 1, -1, 0, -1, -1, cyc);
    $display("run0 toggle: cycles=%0d err=%0d pass=%0d", cyc, err0, pass0);
    chk("toggle.cycles", cyc, 383);
    chk("toggle.pass", int'(pass0), 1);

    // Seed 0xFFFE wraps through 0xFFFF to 0x0000.
    run(1, 0, -1, 0, -1, -1, cyc);
    $display("run1 wrap: cycles=%0d err=%0d pass=%0d", cyc, err1, pass1);
    chk("wrap.cycles", cyc, 24);
    chk("wrap.pass", int'(pass1), 1);
    chk("wrap.err", int'(err1), 0);

    // Stuck-at-zero: 19 mismatches saturate a 4-bit counter.
    run(1, 0, -1, 1, -1, -1, cyc);
    $display("run1 stuck: cycles=%0d err=%0d idx=%0d val=%0d", cyc, err1, fidx1, fval1);
    chk("sat.err", int'(err1), 15);
    chk("sat.pass", int'(pass1), 0);
    chk("sat.idx", int'(fidx1), 0);
    chk("sat.val", int'(fval1), 0);

    // Reset in the middle of CHECK, then confirm the module idles.
    run(1, 0, -1, 1, 10, -1, cyc);
    $display("run1 abort: cycles=%0d busy=%0d", cyc, busy1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort.idle_busy1", int'(busy1), 0);
    chk("abort.idle_done1", int'(done1), 0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
